// File: rtl/instruction_ram_pkg.sv
// ============================================================================
//  Module  : instruction_ram_pkg
//  Brief   : Shared types and constants for the writable instruction RAM:
//            FSM state encoding, NOP word, boot-program words and the
//            instruction field encodings they are built from.
//            Boot program is only used when PROG_PRELOAD_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package instruction_ram_pkg;

    // Init/run sequencer states
    typedef enum logic [0:0] {
        IRAM_INIT = 1'b0,
        IRAM_RUN  = 1'b1
    } iram_state_e;

    // Instruction layout: {op[31:28], mode[27:24], src_t[23:20], dst_t[19:16], dst_reg[15:8], operand[7:0]}
    localparam logic [3:0] c_OP_MOV   = 4'h1;
    localparam logic [3:0] c_OP_ACC   = 4'h2;
    localparam logic [3:0] c_OP_JMP   = 4'h3;
    localparam logic [3:0] c_MODE_PUR = 4'h0;
    localparam logic [3:0] c_MODE_UAD = 4'h1;
    localparam logic [3:0] c_MODE_UNC = 4'h0;
    localparam logic [3:0] c_SRC_NUM  = 4'h1;
    localparam logic [3:0] c_DST_NONE = 4'h0;
    localparam logic [3:0] c_DST_REG  = 4'h2;
    localparam logic [7:0] c_REG_DOUT = 8'h01;
    localparam logic [7:0] c_REG_NONE = 8'h00;

    localparam logic [31:0] INSTR_NOP = 32'd0;

    // MOV PUR NUM 1 -> REG DOUT
    localparam logic [31:0] BOOT_WORD0 = {c_OP_MOV, c_MODE_PUR, c_SRC_NUM, c_DST_REG,  c_REG_DOUT, 8'd1};
    // ACC UAD NUM 40 -> REG DOUT
    localparam logic [31:0] BOOT_WORD1 = {c_OP_ACC, c_MODE_UAD, c_SRC_NUM, c_DST_REG,  c_REG_DOUT, 8'd40};
    // JMP UNC to byte address 4
    localparam logic [31:0] BOOT_WORD2 = {c_OP_JMP, c_MODE_UNC, c_SRC_NUM, c_DST_NONE, c_REG_NONE, 8'd4};

    // Boot image contents for a given word index (NOP beyond the program)
    function automatic logic [31:0] boot_word(input int unsigned idx);
        case (idx)
            0:       boot_word = BOOT_WORD0;
            1:       boot_word = BOOT_WORD1;
            2:       boot_word = BOOT_WORD2;
            default: boot_word = INSTR_NOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_ram_init_seq.sv
// ============================================================================
//  Module  : instr_ram_init_seq
//  Brief   : Post-reset initialisation sequencer. Walks the word index from
//            0 to DEPTH-1, one word per cycle, then parks in RUN. Provides
//            the init write strobe/index/data and registered busy/wr_ready.
//            PROG_PRELOAD_EN selects boot-program contents over all-NOP.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_ram_init_seq
    import instruction_ram_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_init_we,
    output logic [IDX_W-1:0]  o_init_idx,
    output logic [DATA_W-1:0] o_init_data,
    output logic              o_busy,
    output logic              o_wr_ready
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);

    iram_state_e      r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_wr_ready;

    // Sequencer: reset restarts the walk from word 0 regardless of current state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IRAM_INIT;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
        end else begin
            case (r_state)
                IRAM_INIT: begin
                    if (r_cnt == c_LAST_IDX) begin
                        r_state    <= IRAM_RUN;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                IRAM_RUN: begin
                    r_state <= IRAM_RUN;
                end
                default: begin
                    r_state <= IRAM_INIT;
                end
            endcase
        end
    end

    assign o_init_we  = (r_state == IRAM_INIT);
    assign o_init_idx = r_cnt;
    assign o_busy     = r_busy;
    assign o_wr_ready = r_wr_ready;

`ifdef PROG_PRELOAD_EN
    assign o_init_data = DATA_W'(boot_word(32'(r_cnt)));
`else
    assign o_init_data = DATA_W'(INSTR_NOP);
`endif

endmodule

`default_nettype wire

// File: rtl/instruction_ram.sv
// ============================================================================
//  Module  : instruction_ram
//  Brief   : Writable instruction memory for the CPU fetch stage. Byte
//            addressed (word = address>>2), 1-cycle registered read,
//            valid/ready loader write port, self-initialising after reset.
//            Misaligned/out-of-range accesses return NOP with addr_fault
//            on reads and are dropped on writes. Read-first on collisions.
//            Optional: PROG_PRELOAD_EN preloads the boot program (DEPTH>=3).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_ram
    import instruction_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read_en,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              addr_fault,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int          c_WORD_W  = ADDR_W - 2;
    localparam int          c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_DEPTH_U = DEPTH;

    // Reject parameter sets the address space cannot reach
    if ((DEPTH < 1) || (DEPTH > (2 ** (ADDR_W - 2)))) begin : g_depth_range_err
        $error("instruction_ram: DEPTH out of range for ADDR_W");
    end

`ifdef PROG_PRELOAD_EN
    // The boot program occupies words 0..2
    if (DEPTH < 3) begin : g_preload_depth_err
        $error("instruction_ram: PROG_PRELOAD_EN requires DEPTH >= 3");
    end
`endif

    logic                w_init_we;
    logic [c_IDX_W-1:0]  w_init_idx;
    logic [DATA_W-1:0]   w_init_data;
    logic                w_busy;
    logic                w_wr_ready;

    logic [c_WORD_W-1:0] w_rd_word;
    logic [c_WORD_W-1:0] w_wr_word;
    logic [c_IDX_W-1:0]  w_rd_idx;
    logic [c_IDX_W-1:0]  w_wr_idx;
    logic                w_rd_fault;
    logic                w_wr_fault;
    logic                w_wr_fire;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_instruction;
    logic                r_instr_valid;
    logic                r_addr_fault;

    instr_ram_init_seq #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (c_IDX_W)
    ) u_init_seq (
        .i_clk       (clock),
        .i_rst_n     (reset_n),
        .o_init_we   (w_init_we),
        .o_init_idx  (w_init_idx),
        .o_init_data (w_init_data),
        .o_busy      (w_busy),
        .o_wr_ready  (w_wr_ready)
    );

    // Alignment and range are resolved before the array is ever indexed
    assign w_rd_word  = address[ADDR_W-1:2];
    assign w_wr_word  = wr_address[ADDR_W-1:2];
    assign w_rd_fault = (address[1:0] != 2'b00)    || (32'(w_rd_word) >= c_DEPTH_U);
    assign w_wr_fault = (wr_address[1:0] != 2'b00) || (32'(w_wr_word) >= c_DEPTH_U);
    assign w_rd_idx   = w_rd_word[c_IDX_W-1:0];
    assign w_wr_idx   = w_wr_word[c_IDX_W-1:0];
    assign w_wr_fire  = wr_valid && w_wr_ready && !w_wr_fault;

    // Storage write port: init sequencer owns the array until RUN; no writes land on a reset edge
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (w_init_we) begin
                r_mem[w_init_idx] <= w_init_data;
            end else if (w_wr_fire) begin
                r_mem[w_wr_idx] <= wr_data;
            end
        end
    end

    // Fetch register: old array contents are sampled, so a same-edge write is seen one read later
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_instruction <= DATA_W'(INSTR_NOP);
            r_instr_valid <= 1'b0;
            r_addr_fault  <= 1'b0;
        end else if (w_busy) begin
            r_instr_valid <= 1'b0;
        end else if (read_en) begin
            r_instr_valid <= 1'b1;
            if (w_rd_fault) begin
                r_instruction <= DATA_W'(INSTR_NOP);
                r_addr_fault  <= 1'b1;
            end else begin
                r_instruction <= r_mem[w_rd_idx];
                r_addr_fault  <= 1'b0;
            end
        end else begin
            r_instr_valid <= 1'b0;
        end
    end

    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign addr_fault  = r_addr_fault;
    assign wr_ready    = w_wr_ready;
    assign busy        = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_instruction_ram.sv
// ============================================================================
//  Module  : tb_instruction_ram
//  Brief   : Scoreboard bench for instruction_ram. Stimulus pushes expected
//            fetch results; a negedge monitor pops and compares whenever
//            instr_valid is high. A second, shallower instance exposes the
//            out-of-range boundary that the 64-word/8-bit build cannot reach.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_ram;
    import instruction_ram_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 64;
    localparam int DEPTH_SM = 60;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              read_en = 1'b0;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              addr_fault;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_address = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              busy;

    logic [DATA_W-1:0] s_instruction;
    logic              s_instr_valid;
    logic              s_addr_fault;
    logic              s_wr_ready;
    logic              s_busy;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    instruction_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .address     (address),
        .read_en     (read_en),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .addr_fault  (addr_fault),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_address  (wr_address),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    instruction_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH_SM)) u_dut_small (
        .clock       (clk),
        .reset_n     (reset_n),
        .address     (address),
        .read_en     (read_en),
        .instruction (s_instruction),
        .instr_valid (s_instr_valid),
        .addr_fault  (s_addr_fault),
        .wr_valid    (wr_valid),
        .wr_ready    (s_wr_ready),
        .wr_address  (wr_address),
        .wr_data     (wr_data),
        .busy        (s_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value the init walk leaves in word i
    function automatic logic [31:0] init_word(input int i);
`ifdef PROG_PRELOAD_EN
        return boot_word(i);
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: every valid fetch must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && instr_valid) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got instr %h fault %b with nothing expected", instruction, addr_fault);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check({e.name, "_instr"}, instruction, e.instr);
                check({e.name, "_fault"}, 32'(addr_fault), 32'(e.fault));
            end
        end
    end

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [31:0] ei, input logic ef, input string nm);
        exp_t e;
        @(posedge clk); #1;
        read_en = 1'b1;
        address = a;
        e.instr = ei; e.fault = ef; e.name = nm;
        q_exp.push_back(e);
        @(posedge clk); #1;
        read_en = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_valid   = 1'b1;
        wr_address = a;
        wr_data    = d;
        @(posedge clk); #1;
        wr_valid   = 1'b0;
    endtask

    // Read and write the same word on one edge
    task automatic do_rw(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [31:0] ei, input string nm);
        exp_t e;
        @(posedge clk); #1;
        read_en = 1'b1; address = a;
        wr_valid = 1'b1; wr_address = a; wr_data = d;
        e.instr = ei; e.fault = 1'b0; e.name = nm;
        q_exp.push_back(e);
        @(posedge clk); #1;
        read_en = 1'b0; wr_valid = 1'b0;
    endtask

    // Count busy cycles after release; reads are requested early on and must be ignored
    task automatic count_busy(input string nm, input int limit_cycles, output int cnt);
        bit bad_ctl;
        cnt = 0;
        bad_ctl = 1'b0;
        read_en = 1'b1;
        address = '0;
        for (int i = 0; i < limit_cycles; i++) begin
            @(negedge clk);
            if (cnt == 10) read_en = 1'b0;
            if (!busy) break;
            cnt++;
            if (wr_ready !== 1'b0 || instr_valid !== 1'b0) bad_ctl = 1'b1;
        end
        read_en = 1'b0;
        check({nm, "_busy_cycles"}, 32'(cnt), 32'(DEPTH));
        check({nm, "_init_ctl_quiet"}, 32'(bad_ctl), 32'd0);
    endtask

    initial begin
        int cnt;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_instruction", instruction, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(addr_fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        reset_n = 1'b1;

        count_busy("init", 200, cnt);
        check("run_wr_ready", 32'(wr_ready), 32'd1);
        check("run_busy", 32'(busy), 32'd0);

        // Post-init contents
        do_read(8'h00, init_word(0), 1'b0, "boot_w0");
        do_read(8'h04, init_word(1), 1'b0, "boot_w1");
        do_read(8'h08, init_word(2), 1'b0, "boot_w2");

        // Write then read back, then confirm the output holds while idle
        do_write(8'h10, 32'hDEADBEEF);
        do_read(8'h10, 32'hDEADBEEF, 1'b0, "wr_rd_10");
        repeat (2) @(posedge clk);
        #1;
        check("hold_instruction", instruction, 32'hDEADBEEF);
        check("hold_valid_low", 32'(instr_valid), 32'd0);

        // Read-first collision
        do_rw(8'h20, 32'h12345678, 32'd0, "rw_old");
        do_read(8'h20, 32'h12345678, 1'b0, "rw_new");

        // Misaligned read after a non-zero result must return NOP with fault
        do_read(8'h10, 32'hDEADBEEF, 1'b0, "pre_fault");
        do_read(8'h05, 32'd0, 1'b1, "misaligned_rd");
        // Misaligned write aimed near word 1 is discarded
        do_write(8'h06, 32'h55555555);
        do_read(8'h04, init_word(1), 1'b0, "misaligned_wr_drop");

        // Top legal word of the 64-word build
        do_read(8'hFC, 32'd0, 1'b0, "top_word_rd");
        do_write(8'hFC, 32'hA5A5A5A5);
        do_read(8'hFC, 32'hA5A5A5A5, 1'b0, "top_word_wr");
        do_read(8'h10, 32'hDEADBEEF, 1'b0, "unchanged_10");

        // Range boundary on the 60-word instance: word 60 faults, word 59 is legal
        do_write(8'hF0, 32'hCAFEF00D);
        do_read(8'hF0, 32'hCAFEF00D, 1'b0, "w60_big");
        check("w60_small_valid", 32'(s_instr_valid), 32'd1);
        check("w60_small_fault", 32'(s_addr_fault), 32'd1);
        check("w60_small_instr", s_instruction, 32'd0);
        do_write(8'hEC, 32'h0BADC0DE);
        do_read(8'hEC, 32'h0BADC0DE, 1'b0, "w59_big");
        check("w59_small_fault", 32'(s_addr_fault), 32'd0);
        check("w59_small_instr", s_instruction, 32'h0BADC0DE);

        // Reset in the middle of initialisation restarts the full walk
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midinit_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        count_busy("reinit", 200, cnt);
        do_read(8'h10, init_word(4), 1'b0, "reinit_10");
        do_read(8'h20, init_word(8), 1'b0, "reinit_20");
        do_read(8'h00, init_word(0), 1'b0, "reinit_w0");
        do_read(8'hFC, 32'd0, 1'b0, "reinit_fc");

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
